vector_issue_unit: RTL and testbench

VECTOR_ISSUE_UNIT -- requirements
Module: vector_issue_unit

---
 rtl/vector_issue_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_vector_issue_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_unit.sv
// In-order, out-of-FU vector instruction issue unit with per-FU operand scoreboard and DDR arbitration.
// Optional saturating issue/stall counters are enabled by defining ISSUE_PERF_CNT_EN.
module vector_issue_unit #(
  parameter int unsigned       NUM_FU    = 4,
  parameter int unsigned       NUM_VREGS = 8,
  parameter int unsigned       PC_W      = 8,
  parameter logic [NUM_FU-1:0] DDR_MASK  = 4'b0101,
  localparam int unsigned      RW        = $clog2(NUM_VREGS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 ready_o,
  output logic                 done_o,
  input  logic                 abort_i,
  input  logic [PC_W-1:0]      prog_len_i,
  input  logic [7:0]           iters_i,
  output logic [PC_W-1:0]      pc_o,
  input  logic [2:0]           instr_fu_i,
  input  logic [RW-1:0]        instr_va_i,
  input  logic [RW-1:0]        instr_vb_i,
  input  logic [RW-1:0]        instr_vy_i,
  input  logic [2:0]           instr_use_i,
  output logic [NUM_FU-1:0]    fu_valid_o,
  input  logic [NUM_FU-1:0]    fu_ready_i,
  output logic [NUM_FU*RW-1:0] fu_va_o,
  output logic [NUM_FU*RW-1:0] fu_vb_o,
  output logic [NUM_FU*RW-1:0] fu_vy_o,
  output logic [2:0]           ddr_owner_o
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_issue_o,
  output logic [31:0]          perf_stall_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [7:0]        iter_q, iter_d;
  logic [NUM_FU-1:0] valid_q, valid_d;
  logic [RW-1:0]     va_q [NUM_FU];
  logic [RW-1:0]     va_d [NUM_FU];
  logic [RW-1:0]     vb_q [NUM_FU];
  logic [RW-1:0]     vb_d [NUM_FU];
  logic [RW-1:0]     vy_q [NUM_FU];
  logic [RW-1:0]     vy_d [NUM_FU];
  logic [2:0]        use_q [NUM_FU];
  logic [2:0]        use_d [NUM_FU];
  logic              done_q, done_d;
  logic [2:0]        owner_q, owner_d;
  logic              owner_vld_q, owner_vld_d;

  logic [NUM_FU-1:0]    busy;
  logic [7:0]           busy8, ddr8;
  logic [NUM_VREGS-1:0] reg_busy;
  logic                 fu_ok, hazard, ddr_conflict, stall;

  assign busy = ~fu_ready_i | valid_q;

  // Zero-extend per-FU vectors to 8 so any 3-bit FU code indexes safely.
  always_comb begin
    busy8 = '0;
    ddr8  = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      busy8[f] = busy[f];
      ddr8[f]  = DDR_MASK[f];
    end
  end

  always_comb begin
    reg_busy = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (busy[f]) begin
        if (use_q[f][0]) reg_busy[va_q[f]] = 1'b1;
        if (use_q[f][1]) reg_busy[vb_q[f]] = 1'b1;
        if (use_q[f][2]) reg_busy[vy_q[f]] = 1'b1;
      end
    end
  end

  always_comb begin
    fu_ok        = ({29'd0, instr_fu_i} < NUM_FU);
    hazard       = (instr_use_i[0] & reg_busy[instr_va_i]) |
                   (instr_use_i[1] & reg_busy[instr_vb_i]) |
                   (instr_use_i[2] & reg_busy[instr_vy_i]);
    ddr_conflict = ddr8[instr_fu_i] & (|(busy8 & ddr8));
    stall        = fu_ok & (busy8[instr_fu_i] | hazard | ddr_conflict);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iter_d      = iter_q;
    valid_d     = '0;
    va_d        = va_q;
    vb_d        = vb_q;
    vy_d        = vy_q;
    use_d       = use_q;
    done_d      = 1'b0;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d    = '0;
          iter_d  = (iters_i == 8'd0) ? 8'd1 : iters_i;
          state_d = (prog_len_i == '0) ? ST_DRAIN : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort_i) begin
          state_d = ST_DRAIN;
        end else if (!stall) begin
          for (int unsigned f = 0; f < NUM_FU; f++) begin
            if ({29'd0, instr_fu_i} == f) begin
              valid_d[f] = 1'b1;
              va_d[f]    = instr_va_i;
              vb_d[f]    = instr_vb_i;
              vy_d[f]    = instr_vy_i;
              use_d[f]   = instr_use_i;
            end
          end
          if (fu_ok && ddr8[instr_fu_i]) begin
            owner_d     = instr_fu_i;
            owner_vld_d = 1'b1;
          end
          if (pc_q == prog_len_i - PC_W'(1)) begin
            if (iter_q > 8'd1) begin
              pc_d   = '0;
              iter_d = iter_q - 8'd1;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (busy == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      iter_q      <= '0;
      valid_q     <= '0;
      done_q      <= 1'b0;
      owner_q     <= 3'd7;
      owner_vld_q <= 1'b0;
      for (int unsigned f = 0; f < NUM_FU; f++) begin
        va_q[f]  <= '0;
        vb_q[f]  <= '0;
        vy_q[f]  <= '0;
        use_q[f] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iter_q      <= iter_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      va_q        <= va_d;
      vb_q        <= vb_d;
      vy_q        <= vy_d;
      use_q       <= use_d;
    end
  end

  assign ready_o     = (state_q == ST_IDLE);
  assign done_o      = done_q;
  assign pc_o        = pc_q;
  assign fu_valid_o  = valid_q;
  // Owner is tracked as the last DDR issue and shown only while that FU stays busy.
  assign ddr_owner_o = (owner_vld_q && busy8[owner_q]) ? owner_q : 3'd7;

  always_comb begin
    fu_va_o = '0;
    fu_vb_o = '0;
    fu_vy_o = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      fu_va_o[f*RW +: RW] = va_q[f];
      fu_vb_o[f*RW +: RW] = vb_q[f];
      fu_vy_o[f*RW +: RW] = vy_q[f];
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ST_IDLE && start_i) begin
      perf_issue_d = '0;
      perf_stall_d = '0;
    end else if (state_q == ST_ISSUE && !abort_i) begin
      if (stall) begin
        if (perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
      end else if (fu_ok && perf_issue_q != '1) begin
        perf_issue_d = perf_issue_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_o = perf_issue_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_vector_issue_unit.sv
// Scoreboard bench for vector_issue_unit: directed programs, expected FU pulses queued at launch.
module tb_vector_issue_unit;
  localparam int NF  = 4;
  localparam int RW  = 3;
  localparam int PCW = 8;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b0;
  logic           start_i = 1'b0;
  logic           abort_i = 1'b0;
  logic           ready_o, done_o;
  logic [PCW-1:0] prog_len_i = '0;
  logic [7:0]     iters_i = '0;
  logic [PCW-1:0] pc_o;
  logic [2:0]     instr_fu_i, instr_use_i;
  logic [RW-1:0]  instr_va_i, instr_vb_i, instr_vy_i;
  logic [NF-1:0]  fu_valid_o;
  logic [NF-1:0]  fu_ready_i = '1;
  logic [NF*RW-1:0] fu_va_o, fu_vb_o, fu_vy_o;
  logic [2:0]     ddr_owner_o;

  always #5 clk = ~clk;

  vector_issue_unit #(.NUM_FU(NF), .NUM_VREGS(8), .PC_W(PCW), .DDR_MASK(4'b0101)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .ready_o(ready_o), .done_o(done_o),
    .abort_i(abort_i), .prog_len_i(prog_len_i), .iters_i(iters_i), .pc_o(pc_o),
    .instr_fu_i(instr_fu_i), .instr_va_i(instr_va_i), .instr_vb_i(instr_vb_i),
    .instr_vy_i(instr_vy_i), .instr_use_i(instr_use_i), .fu_valid_o(fu_valid_o),
    .fu_ready_i(fu_ready_i), .fu_va_o(fu_va_o), .fu_vb_o(fu_vb_o), .fu_vy_o(fu_vy_o),
    .ddr_owner_o(ddr_owner_o)
  );

  // Instruction memory, read combinationally at pc_o.
  logic [2:0] im_fu [16];
  logic [2:0] im_use[16];
  logic [2:0] im_va [16];
  logic [2:0] im_vb [16];
  logic [2:0] im_vy [16];
  assign instr_fu_i  = im_fu [pc_o[3:0]];
  assign instr_use_i = im_use[pc_o[3:0]];
  assign instr_va_i  = im_va [pc_o[3:0]];
  assign instr_vb_i  = im_vb [pc_o[3:0]];
  assign instr_vy_i  = im_vy [pc_o[3:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FU model: after a pulse, ready is low for lat[f] cycles starting in the pulse cycle.
  int lat[NF];
  int cnt[NF];
  always @(posedge clk) begin
    #1;
    for (int f = 0; f < NF; f++) begin
      if (!rst_ni) cnt[f] = 0;
      else if (fu_valid_o[f] && lat[f] > 0) cnt[f] = lat[f];
      else if (cnt[f] > 0) cnt[f]--;
      fu_ready_i[f] = (cnt[f] == 0);
    end
  end

  typedef struct {int fu; int va; int vb; int vy; int cyc;} exp_t;
  exp_t sbq[$];
  int checks = 0;
  int bad = 0;
  int done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int fu, input int va, input int vb, input int vy, input int c);
    exp_t e;
    e.fu = fu; e.va = va; e.vb = vb; e.vy = vy; e.cyc = c;
    sbq.push_back(e);
  endtask

  // Monitor: every FU pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_ni) begin
      for (int f = 0; f < NF; f++) begin
        if (fu_valid_o[f]) begin
          if (sbq.size() == 0) begin
            checks++;
            bad++;
            $display("FAIL unexpected_pulse: fu %0d at cycle %0d, none expected", f, cyc);
          end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("pulse_fu", f, e.fu);
            chk("pulse_cyc", cyc, e.cyc);
            chk("pulse_va", int'(fu_va_o[f*RW +: RW]), e.va);
            chk("pulse_vb", int'(fu_vb_o[f*RW +: RW]), e.vb);
            chk("pulse_vy", int'(fu_vy_o[f*RW +: RW]), e.vy);
          end
        end
      end
      if (done_o) done_seen++;
    end
  end

  task automatic load(input int idx, input int fu, input int va, input int vb, input int vy, input int u);
    im_fu[idx] = 3'(fu); im_va[idx] = 3'(va); im_vb[idx] = 3'(vb);
    im_vy[idx] = 3'(vy); im_use[idx] = 3'(u);
  endtask

  task automatic start_run(input int len, input int it, output int s);
    @(posedge clk); #1;
    s = cyc;
    prog_len_i = PCW'(len);
    iters_i = 8'(it);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_done(input string name, input int exp);
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done_o) break;
      n++;
    end
    if (n >= 200) begin
      checks++;
      bad++;
      $display("FAIL %s: done_o never seen, expected at cycle %0d", name, exp);
    end else begin
      chk(name, cyc, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    for (int i = 0; i < 16; i++) load(i, 4, 0, 0, 0, 0);
    for (int f = 0; f < NF; f++) begin lat[f] = 0; cnt[f] = 0; end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", fu_valid_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_owner", ddr_owner_o, 7);
    chk("rst_pc", pc_o, 0);
    rst_ni = 1'b1;

    // Three independent FUs, all ready: back-to-back pulses.
    load(0, 0, 1, 2, 3, 7); load(1, 1, 4, 5, 6, 7); load(2, 2, 7, 0, 1, 7);
    @(negedge clk);
    chk("idle_ready", ready_o, 1);
    start_run(3, 1, s);
    push(0, 1, 2, 3, s + 2); push(1, 4, 5, 6, s + 3); push(2, 7, 0, 1, s + 4);
    wait_cyc(s + 2);
    chk("issue_ready", ready_o, 0);
    wait_done("t1_done", s + 6);

    // RAW on v3 through FU1 (busy 10 cycles) to FU2.
    load(0, 1, 0, 0, 3, 4); load(1, 2, 3, 0, 0, 1);
    lat[1] = 10;
    start_run(2, 1, s);
    push(1, 0, 0, 3, s + 2); push(2, 3, 0, 0, s + 13);
    wait_done("t2_done", s + 15);
    lat[1] = 0;

    // FU0 and FU2 share DDR: FU2 waits for FU0 to go idle.
    load(0, 0, 1, 1, 1, 1); load(1, 2, 2, 2, 2, 1);
    lat[0] = 4;
    start_run(2, 1, s);
    push(0, 1, 1, 1, s + 2); push(2, 2, 2, 2, s + 7);
    wait_cyc(s + 2); chk("ddr_owner_fu0", ddr_owner_o, 0);
    wait_cyc(s + 5); chk("ddr_owner_fu0_late", ddr_owner_o, 0);
    wait_cyc(s + 6); chk("ddr_owner_gap", ddr_owner_o, 7);
    wait_cyc(s + 7); chk("ddr_owner_fu2", ddr_owner_o, 2);
    wait_cyc(s + 8); chk("ddr_owner_free", ddr_owner_o, 7);
    wait_done("t3_done", s + 9);
    lat[0] = 0;

    // Two instructions repeated three times; a stray start mid-run must be ignored.
    load(0, 1, 1, 2, 3, 0); load(1, 3, 4, 5, 6, 0);
    start_run(2, 3, s);
    for (int k = 0; k < 3; k++) begin
      push(1, 1, 2, 3, s + 2 + 2 * k);
      push(3, 4, 5, 6, s + 3 + 2 * k);
    end
    for (int k = 0; k < 6; k++) begin
      wait_cyc(s + 1 + k);
      chk("pc_seq", pc_o, k % 2);
      if (k == 3) begin
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
    end
    wait_done("t4_done", s + 9);

    // Abort while FU3 is busy and the next instruction is stalled on it.
    load(0, 3, 0, 0, 0, 0); load(1, 3, 1, 1, 1, 0); load(2, 0, 2, 2, 2, 0);
    lat[3] = 8;
    start_run(3, 1, s);
    push(3, 0, 0, 0, s + 2);
    wait_cyc(s + 4);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    wait_done("t5_abort_done", s + 11);
    lat[3] = 0;

    // Empty program goes straight to drain.
    start_run(0, 1, s);
    wait_done("t6_empty_done", s + 2);
    @(negedge clk);
    chk("t6_ready_after", ready_o, 1);

    // Out-of-range FU code is a NOP even when its operands alias a busy register; iters=0 runs once.
    load(0, 0, 1, 2, 3, 7); load(1, 4, 1, 2, 3, 7); load(2, 1, 4, 5, 6, 7);
    start_run(3, 0, s);
    push(0, 1, 2, 3, s + 2); push(1, 4, 5, 6, s + 4);
    wait_done("t7_nop_done", s + 6);

    // Asynchronous reset in the middle of a stalled run.
    load(0, 1, 1, 2, 3, 7); load(1, 1, 0, 0, 0, 0);
    lat[1] = 20;
    start_run(2, 1, s);
    push(1, 1, 2, 3, s + 2);
    wait_cyc(s + 5);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_ready", ready_o, 1);
    chk("arst_valid", fu_valid_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_owner", ddr_owner_o, 7);
    chk("arst_pc", pc_o, 0);
    chk("arst_va", int'(fu_va_o), 0);
    chk("arst_vy", int'(fu_vy_o), 0);
    lat[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_ready_after", ready_o, 1);
    chk("arst_no_done", done_o, 0);

    chk("done_count", done_seen, 7);
    chk("sb_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end
endmodule
